// File: rtl/ft60x_fifo_bridge.sv
// FT60x 245-synchronous FIFO bridge: FTDI RX bursts into the fa FIFO, af FIFO words out as TX bursts.
// Define FT60X_BURST_STATS_EN to add saturating word/burst counters with a stats_clr input.
module ft60x_fifo_bridge #(
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 256,
   parameter int ARB_MODE  = 0,
   parameter int TA_CYCLES = 1,
   localparam int BE_W     = DATA_W / 8
) (
   input  logic              ftdi_clk,
   input  logic              nreset,
   input  logic [DATA_W-1:0] ftdi_data_i,
   output logic [DATA_W-1:0] ftdi_data_o,
   output logic              ftdi_data_oe,
   input  logic [BE_W-1:0]   ftdi_be_i,
   output logic [BE_W-1:0]   ftdi_be_o,
   input  logic              ftdi_nrxf,
   input  logic              ftdi_ntxe,
   output logic              ftdi_nrd,
   output logic              ftdi_nwr,
   output logic              ftdi_noe,
   output logic [DATA_W-1:0] ch_fa_data,
   output logic [BE_W-1:0]   ch_fa_be,
   output logic              ch_fa_wren,
   input  logic              ch_fa_almost_full,
   input  logic [DATA_W-1:0] ch_af_data,
   output logic              ch_af_rden,
   input  logic              ch_af_empty,
   output logic [3:0]        actual_state
`ifdef FT60X_BURST_STATS_EN
   ,
   input  logic              stats_clr,
   output logic [31:0]       rx_word_cnt,
   output logic [31:0]       tx_word_cnt,
   output logic [15:0]       rx_burst_cnt,
   output logic [15:0]       tx_burst_cnt
`endif
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      RX_OE    = 4'd1,
      RX_READ  = 4'd2,
      TX_LOAD  = 4'd3,
      TX_WRITE = 4'd4,
      TURN     = 4'd5
   } state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [2:0]        ta_cnt, ta_cnt_n;
   logic              rr_tx, rr_tx_n;
   logic [DATA_W-1:0] skid0, skid1, skid0_n, skid1_n;
   logic [1:0]        occ, occ_n;
   logic              rd_vld_p1;
   logic              rden_n, can_read;
   logic              rx_cap, tx_acc, rx_req, tx_req, burst_done;

   assign actual_state = state;

   always_comb begin
      rx_cap   = (state == RX_READ) & ~ftdi_nrd & ~ftdi_nrxf;
      tx_acc   = (state == TX_WRITE) & ~ftdi_nwr & ~ftdi_ntxe;
      rx_req   = ~ftdi_nrxf & ~ch_fa_almost_full;
      tx_req   = ~ftdi_ntxe & ((occ != 2'd0) | ~ch_af_empty);
      skid0_n  = skid0;
      skid1_n  = skid1;
      occ_n    = occ;
      // af read data lands one cycle after the strobe; push it into the skid tail
      case ({rd_vld_p1, tx_acc})
         2'b01: begin
            skid0_n = skid1;
            occ_n   = occ - 2'd1;
         end
         2'b10: begin
            if (occ == 2'd0) skid0_n = ch_af_data;
            else             skid1_n = ch_af_data;
            occ_n = occ + 2'd1;
         end
         2'b11: begin
            if (occ == 2'd1) skid0_n = ch_af_data;
            else begin
               skid0_n = skid1;
               skid1_n = ch_af_data;
            end
         end
         default: ;
      endcase
      // af empty lags a read by one cycle, so reads are never issued back to back
      can_read   = ~ch_af_empty & ~ch_af_rden & (occ_n < 2'd2);
      state_n    = state;
      cnt_n      = cnt;
      ta_cnt_n   = ta_cnt;
      rr_tx_n    = rr_tx;
      rden_n     = 1'b0;
      burst_done = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (rx_req && (!tx_req || ARB_MODE == 1 || !rr_tx)) state_n = RX_OE;
            else if (tx_req)                                   state_n = TX_LOAD;
         end
         RX_OE: state_n = RX_READ;
         RX_READ: begin
            if (rx_cap) cnt_n = cnt + CNT_W'(1);
            if (ftdi_nrxf || ch_fa_almost_full || cnt_n >= CNT_W'(MAX_BURST)) begin
               burst_done = 1'b1;
               rr_tx_n    = 1'b1;
            end
         end
         TX_LOAD: begin
            rden_n = can_read;
            if (occ_n != 2'd0) state_n = TX_WRITE;
         end
         TX_WRITE: begin
            if (tx_acc) cnt_n = cnt + CNT_W'(1);
            if (ftdi_ntxe || cnt_n >= CNT_W'(MAX_BURST) ||
                (occ_n == 2'd0 && !ch_af_rden && ch_af_empty)) begin
               burst_done = 1'b1;
               rr_tx_n    = 1'b0;
            end else begin
               rden_n = can_read;
            end
         end
         TURN: begin
            if (ta_cnt == 3'(TA_CYCLES - 1)) state_n = IDLE;
            else                             ta_cnt_n = ta_cnt + 3'd1;
         end
         default: state_n = IDLE;
      endcase
      if (burst_done) begin
         state_n  = TURN;
         ta_cnt_n = '0;
      end
   end

   always_ff @(posedge ftdi_clk) begin
      if (!nreset) begin
         state        <= IDLE;
         cnt          <= '0;
         ta_cnt       <= '0;
         rr_tx        <= 1'b0;
         occ          <= 2'd0;
         rd_vld_p1    <= 1'b0;
         ftdi_nrd     <= 1'b1;
         ftdi_nwr     <= 1'b1;
         ftdi_noe     <= 1'b1;
         ftdi_data_oe <= 1'b0;
         ftdi_data_o  <= '0;
         ftdi_be_o    <= '1;
         ch_fa_wren   <= 1'b0;
         ch_af_rden   <= 1'b0;
         ch_fa_data   <= '0;
         ch_fa_be     <= '0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         ta_cnt       <= ta_cnt_n;
         rr_tx        <= rr_tx_n;
         occ          <= occ_n;
         rd_vld_p1    <= ch_af_rden;
         ftdi_noe     <= !(state_n == RX_OE || state_n == RX_READ);
         ftdi_nrd     <= (state_n != RX_READ);
         ftdi_nwr     <= !(state_n == TX_WRITE && occ_n != 2'd0);
         ftdi_data_oe <= (state_n == TX_WRITE);
         ftdi_data_o  <= skid0_n;
         ftdi_be_o    <= '1;
         ch_af_rden   <= rden_n;
         ch_fa_wren   <= rx_cap;
         if (rx_cap) begin
            ch_fa_data <= ftdi_data_i;
            ch_fa_be   <= ftdi_be_i;
         end
      end
   end

   always_ff @(posedge ftdi_clk) begin
      skid0 <= skid0_n;
      skid1 <= skid1_n;
   end

`ifdef FT60X_BURST_STATS_EN
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge ftdi_clk) begin
      if (!nreset || stats_clr) begin
         rx_word_cnt  <= '0;
         tx_word_cnt  <= '0;
         rx_burst_cnt <= '0;
         tx_burst_cnt <= '0;
      end else begin
         if (rx_cap) rx_word_cnt <= sat_inc32(rx_word_cnt);
         if (tx_acc) tx_word_cnt <= sat_inc32(tx_word_cnt);
         if (state == IDLE && state_n == RX_OE)   rx_burst_cnt <= sat_inc16(rx_burst_cnt);
         if (state == IDLE && state_n == TX_LOAD) tx_burst_cnt <= sat_inc16(tx_burst_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_ft60x_fifo_bridge.sv
// Directed bench for ft60x_fifo_bridge: two instances (default and MAX_BURST=4/ARB_MODE=1/TA_CYCLES=2)
// driven by small FT60x-bus and af-FIFO models.
module tb_ft60x_fifo_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        nreset [2];
   logic [31:0] data_i [2], data_o [2], fa_data [2], af_data [2];
   logic [3:0]  be_i [2], be_o [2], fa_be [2], st [2];
   logic        oe [2], nrxf [2], ntxe [2], nrd [2], nwr [2], noe [2];
   logic        fa_wren [2], fa_af [2], af_rden [2], af_empty [2];

   int          rx_avail [2], tx_space [2];
   logic [31:0] rx_next [2], fa_exp [2], tx_exp [2];
   logic [31:0] af_mem [2][64];
   int          af_wr [2], af_rd [2];
   int          fa_cnt [2], tx_cnt [2], rden_cnt [2], uflow [2];
   int          btype [2][16], blen [2][16], bnum [2], tlen [2][16], tnum [2];
   int          cur_len [2], cur_turn [2];
   logic [3:0]  prev_st [2];
   logic        cap_s [2], acc_s [2], rd_s [2];
   logic [31:0] wd_s [2];

   int n_chk = 0;
   int n_fail = 0;

   ft60x_fifo_bridge #(.DATA_W(32), .MAX_BURST(256), .ARB_MODE(0), .TA_CYCLES(1)) u0 (
      .ftdi_clk(clk), .nreset(nreset[0]),
      .ftdi_data_i(data_i[0]), .ftdi_data_o(data_o[0]), .ftdi_data_oe(oe[0]),
      .ftdi_be_i(be_i[0]), .ftdi_be_o(be_o[0]),
      .ftdi_nrxf(nrxf[0]), .ftdi_ntxe(ntxe[0]),
      .ftdi_nrd(nrd[0]), .ftdi_nwr(nwr[0]), .ftdi_noe(noe[0]),
      .ch_fa_data(fa_data[0]), .ch_fa_be(fa_be[0]), .ch_fa_wren(fa_wren[0]),
      .ch_fa_almost_full(fa_af[0]),
      .ch_af_data(af_data[0]), .ch_af_rden(af_rden[0]), .ch_af_empty(af_empty[0]),
      .actual_state(st[0]));

   ft60x_fifo_bridge #(.DATA_W(32), .MAX_BURST(4), .ARB_MODE(1), .TA_CYCLES(2)) u1 (
      .ftdi_clk(clk), .nreset(nreset[1]),
      .ftdi_data_i(data_i[1]), .ftdi_data_o(data_o[1]), .ftdi_data_oe(oe[1]),
      .ftdi_be_i(be_i[1]), .ftdi_be_o(be_o[1]),
      .ftdi_nrxf(nrxf[1]), .ftdi_ntxe(ntxe[1]),
      .ftdi_nrd(nrd[1]), .ftdi_nwr(nwr[1]), .ftdi_noe(noe[1]),
      .ch_fa_data(fa_data[1]), .ch_fa_be(fa_be[1]), .ch_fa_wren(fa_wren[1]),
      .ch_fa_almost_full(fa_af[1]),
      .ch_af_data(af_data[1]), .ch_af_rden(af_rden[1]), .ch_af_empty(af_empty[1]),
      .actual_state(st[1]));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         nrxf[i]     = (rx_avail[i] == 0);
         ntxe[i]     = (tx_space[i] == 0);
         data_i[i]   = rx_next[i];
         be_i[i]     = 4'hF;
         af_empty[i] = (af_wr[i] == af_rd[i]);
         fa_af[i]    = 1'b0;
      end
   end

   // Bus/FIFO models and burst log: sample before the edge, update 1 ns after it.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         cap_s[i] = !nrd[i] && !nrxf[i];
         acc_s[i] = !nwr[i] && !ntxe[i];
         rd_s[i]  = af_rden[i];
         wd_s[i]  = data_o[i];
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         if (cap_s[i]) begin
            rx_avail[i]--;
            rx_next[i]++;
            cur_len[i]++;
         end
         if (acc_s[i]) begin
            check_eq("tx_word_order", wd_s[i], tx_exp[i]);
            tx_exp[i]++;
            tx_cnt[i]++;
            tx_space[i]--;
            cur_len[i]++;
         end
         if (rd_s[i]) begin
            rden_cnt[i]++;
            if (af_wr[i] == af_rd[i]) uflow[i]++;
            else begin
               af_data[i] = af_mem[i][af_rd[i] % 64];
               af_rd[i]++;
            end
         end
         if (fa_wren[i]) begin
            check_eq("fa_word_order", fa_data[i], fa_exp[i]);
            fa_exp[i]++;
            fa_cnt[i]++;
         end
         if (prev_st[i] == 4'd0 && st[i] != 4'd0) cur_len[i] = 0;
         if ((prev_st[i] == 4'd2 || prev_st[i] == 4'd4) && st[i] == 4'd5) begin
            if (bnum[i] < 16) begin
               btype[i][bnum[i]] = (prev_st[i] == 4'd2) ? 1 : 2;
               blen[i][bnum[i]]  = cur_len[i];
            end
            bnum[i]++;
         end
         if (st[i] == 4'd5) cur_turn[i]++;
         if (prev_st[i] == 4'd5 && st[i] != 4'd5) begin
            if (tnum[i] < 16) tlen[i][tnum[i]] = cur_turn[i];
            tnum[i]++;
            cur_turn[i] = 0;
         end
         prev_st[i] = st[i];
      end
   end

   task automatic clr(input int i);
      fa_cnt[i] = 0; tx_cnt[i] = 0; rden_cnt[i] = 0;
      bnum[i] = 0; tnum[i] = 0; cur_turn[i] = 0;
   endtask

   task automatic af_push(input int i, input int n, input logic [31:0] base);
      for (int k = 0; k < n; k++) begin
         af_mem[i][af_wr[i] % 64] = base + 32'(k);
         af_wr[i]++;
      end
   endtask

   task automatic wait_quiet(input int i, input string tag);
      int q, n;
      q = 0; n = 0;
      while (q < 4 && n < 2000) begin
         @(negedge clk);
         n++;
         if (st[i] == 4'd0) q++;
         else q = 0;
      end
      check_eq(tag, 64'(q >= 4), 64'd1);
   endtask

   initial begin
      int n;
      int rden_first;
      for (int i = 0; i < 2; i++) begin
         nreset[i] = 1'b0; rx_avail[i] = 0; tx_space[i] = 0;
         af_wr[i] = 0; af_rd[i] = 0; af_data[i] = '0; uflow[i] = 0;
         cur_len[i] = 0; prev_st[i] = 4'd0;
         clr(i);
      end
      rx_next[0] = 32'h1;    fa_exp[0] = 32'h1;
      rx_next[1] = 32'h1000; fa_exp[1] = 32'h1000;
      tx_exp[0] = '0; tx_exp[1] = '0;
      repeat (3) @(negedge clk);

      check_eq("rst_nrd", 64'(nrd[0]), 64'd1);
      check_eq("rst_nwr", 64'(nwr[0]), 64'd1);
      check_eq("rst_noe", 64'(noe[0]), 64'd1);
      check_eq("rst_data_oe", 64'(oe[0]), 64'd0);
      check_eq("rst_data_o", 64'(data_o[0]), 64'd0);
      check_eq("rst_be_o", 64'(be_o[0]), 64'hF);
      check_eq("rst_fa_wren", 64'(fa_wren[0]), 64'd0);
      check_eq("rst_af_rden", 64'(af_rden[0]), 64'd0);
      check_eq("rst_fa_data", 64'(fa_data[0]), 64'd0);
      check_eq("rst_fa_be", 64'(fa_be[0]), 64'd0);
      check_eq("rst_state", 64'(st[0]), 64'd0);
      check_eq("rst_state_u1", 64'(st[1]), 64'd0);
      nreset[0] = 1'b1; nreset[1] = 1'b1;
      repeat (2) @(negedge clk);

      // RX burst of 10 words
      clr(0);
      rx_avail[0] = 10;
      n = 0;
      while (noe[0] && n < 20) begin @(negedge clk); n++; end
      check_eq("rx_noe_fall", 64'(noe[0]), 64'd0);
      check_eq("rx_nrd_high_with_noe", 64'(nrd[0]), 64'd1);
      @(negedge clk);
      check_eq("rx_nrd_fall", 64'(nrd[0]), 64'd0);
      wait_quiet(0, "rx_quiet");
      check_eq("rx_wren_cnt", 64'(fa_cnt[0]), 64'd10);
      check_eq("rx_last_word", 64'(fa_data[0]), 64'hA);
      check_eq("rx_bursts", 64'(bnum[0]), 64'd1);
      check_eq("rx_burst_len", 64'(blen[0][0]), 64'd10);
      check_eq("rx_turn_cnt", 64'(tnum[0]), 64'd1);
      check_eq("rx_turn_len", 64'(tlen[0][0]), 64'd1);

      // TX burst of 5 words, ntxe held low
      clr(0);
      af_push(0, 5, 32'h100);
      tx_exp[0] = 32'h100;
      tx_space[0] = 1000;
      wait_quiet(0, "tx_quiet");
      check_eq("tx_accept_cnt", 64'(tx_cnt[0]), 64'd5);
      check_eq("tx_rden_cnt", 64'(rden_cnt[0]), 64'd5);
      check_eq("tx_bursts", 64'(bnum[0]), 64'd1);
      check_eq("tx_burst_type", 64'(btype[0][0]), 64'd2);
      check_eq("tx_burst_len", 64'(blen[0][0]), 64'd5);
      tx_space[0] = 0;
      @(negedge clk);

      // TX backpressure: FTDI takes 3 of 6, then the rest
      clr(0);
      af_push(0, 6, 32'h200);
      tx_exp[0] = 32'h200;
      tx_space[0] = 3;
      wait_quiet(0, "bp_quiet1");
      check_eq("bp_accept1", 64'(tx_cnt[0]), 64'd3);
      check_eq("bp_burst1_len", 64'(blen[0][0]), 64'd3);
      rden_first = rden_cnt[0];
      clr(0);
      tx_space[0] = 100;
      wait_quiet(0, "bp_quiet2");
      check_eq("bp_accept2", 64'(tx_cnt[0]), 64'd3);
      check_eq("bp_burst2_len", 64'(blen[0][0]), 64'd3);
      check_eq("bp_next_word", 64'(tx_exp[0]), 64'h206);
      check_eq("bp_rden_total", 64'(rden_first + rden_cnt[0]), 64'd6);
      tx_space[0] = 0;
      @(negedge clk);

      // Round-robin with both sides requesting
      clr(0);
      af_push(0, 8, 32'h300);
      tx_exp[0] = 32'h300;
      rx_avail[0] = 600;
      tx_space[0] = 1000;
      n = 0;
      while (bnum[0] < 3 && n < 2000) begin @(negedge clk); n++; end
      check_eq("rr_three_bursts", 64'(bnum[0] >= 3), 64'd1);
      rx_avail[0] = 0;
      wait_quiet(0, "rr_quiet");
      check_eq("rr_burst0_rx", 64'(btype[0][0]), 64'd1);
      check_eq("rr_burst1_tx", 64'(btype[0][1]), 64'd2);
      check_eq("rr_burst2_rx", 64'(btype[0][2]), 64'd1);
      check_eq("rr_rx_max_len", 64'(blen[0][0]), 64'd256);
      check_eq("rr_tx_len", 64'(blen[0][1]), 64'd8);
      tx_space[0] = 0;

      // MAX_BURST=4, TA_CYCLES=2: 9 RX words
      clr(1);
      rx_avail[1] = 9;
      wait_quiet(1, "mb_quiet");
      check_eq("mb_bursts", 64'(bnum[1]), 64'd3);
      check_eq("mb_len0", 64'(blen[1][0]), 64'd4);
      check_eq("mb_len1", 64'(blen[1][1]), 64'd4);
      check_eq("mb_len2", 64'(blen[1][2]), 64'd1);
      check_eq("mb_turn0", 64'(tlen[1][0]), 64'd2);
      check_eq("mb_turn1", 64'(tlen[1][1]), 64'd2);
      check_eq("mb_words", 64'(fa_cnt[1]), 64'd9);

      // ARB_MODE=1: RX keeps priority while it requests
      clr(1);
      af_push(1, 3, 32'h400);
      tx_exp[1] = 32'h400;
      rx_avail[1] = 9;
      tx_space[1] = 100;
      wait_quiet(1, "pri_quiet");
      check_eq("pri_b0", 64'(btype[1][0]), 64'd1);
      check_eq("pri_b1", 64'(btype[1][1]), 64'd1);
      check_eq("pri_b2", 64'(btype[1][2]), 64'd1);
      check_eq("pri_b3", 64'(btype[1][3]), 64'd2);
      check_eq("pri_tx_len", 64'(blen[1][3]), 64'd3);
      check_eq("pri_tx_cnt", 64'(tx_cnt[1]), 64'd3);
      tx_space[1] = 0;

      // Reset in the middle of a TX burst
      clr(0);
      af_push(0, 20, 32'h500);
      tx_exp[0] = 32'h500;
      tx_space[0] = 1000;
      n = 0;
      while (st[0] != 4'd4 && n < 50) begin @(negedge clk); n++; end
      check_eq("rst_tx_reached", 64'(st[0]), 64'd4);
      nreset[0] = 1'b0;
      @(posedge clk);
      #1;
      check_eq("rst_tx_nwr", 64'(nwr[0]), 64'd1);
      check_eq("rst_tx_oe", 64'(oe[0]), 64'd0);
      check_eq("rst_tx_state", 64'(st[0]), 64'd0);
      check_eq("rst_tx_rden", 64'(af_rden[0]), 64'd0);
      tx_space[0] = 0;
      @(negedge clk);
      nreset[0] = 1'b1;
      repeat (3) @(negedge clk);

      check_eq("af_underflow_u0", 64'(uflow[0]), 64'd0);
      check_eq("af_underflow_u1", 64'(uflow[1]), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
